result_readout: RTL
===================

Name: result_readout

Overview:
- Downstream consumer of the matrix core's result memory port.
- On the rising edge of the core's finish, fetches NUM_RESULTS 32-bit result words through the chip-select/ready read port.
- Serialises each word MSB-byte-first onto an 8-bit valid/ready byte stream towards the off-chip interface.
- Raises a one-cycle done pulse when the last byte is accepted, and flags a sticky error if the core never answers a read.

Parameters:
- NUM_RESULTS, 16, number of 32-bit result words read per run (4x4 result matrix).
- CNT_W, 5, width of word counter; must hold NUM_RESULTS.
- TIMEOUT, 64, cycles to wait for ry after a request before aborting.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- finish  input  1  core computation complete (level); rising edge starts a readout.
- ry  input  1  core read ready; read_data valid in the same cycle.
- read_data  input  32  result word from core.
- cs_n  output  1  active-low read request to core, one-cycle pulse per word.
- out_data  output  8  serialised result byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts byte when high together with out_valid.
- word_cnt  output  CNT_W  index of word currently being fetched or sent.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after final byte accepted.
- err  output  1  sticky timeout flag; cleared at next readout start or by rst.

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, cs_n=1, out_valid=0, out_data=0, word_cnt=0, busy=0, done=0, err=0, finish edge detector register=0.
- Reset mid-operation aborts immediately; no further cs_n pulses; a partially sent word is discarded.
- Start condition: finish=1 and finish registered=0, in IDLE. Finish edges outside IDLE are ignored.
- If finish is held high through reset, that counts as one edge after reset.
- States:
  - IDLE: on start, clear err and word_cnt, go to REQ.
  - REQ: cs_n=0 for exactly this one cycle. Load timeout counter = TIMEOUT. Go to WAIT.
  - WAIT: cs_n=1. If ry=1, capture read_data into shift register, byte index=0, go to SEND; minimum request-to-capture latency is 1 cycle. Otherwise decrement the timeout counter. On reaching 0: err=1, go to IDLE, no done pulse.
  - SEND: out_valid=1, out_data=shift[31:24]. On out_valid and out_ready: shift left 8 and increment byte index.
    - After the 4th byte is accepted with word_cnt<NUM_RESULTS-1: increment word_cnt, go to REQ.
    - After the 4th byte with word_cnt=NUM_RESULTS-1: done=1 next cycle, go to IDLE.
  - out_data/out_valid stable while out_valid=1 and out_ready=0.
  - Bytes may transfer on consecutive cycles.
- ry outside WAIT is ignored; no capture, no state change.
- Timing:
  - Last byte of word n accepted -> cs_n low for word n+1 on the next cycle.
  - Per word minimum: 1 (REQ) + 1 (WAIT) + 4 (SEND) = 6 cycles.
- word_cnt holds NUM_RESULTS-1 after completion until the next start; no wrap beyond NUM_RESULTS-1.
- out_valid=0 in IDLE, REQ and WAIT; busy=0 only in IDLE.
- done and err are never asserted in the same cycle.

Test Plan:
- Normal run, NUM_RESULTS=16:
  - Stimulus: core returns ry one cycle after each cs_n with word k=32'hA0B0C0D0+k; out_ready tied 1.
  - Required: 64 bytes A0,B0,C0,D0,A0,B0,C0,D1,...; 16 cs_n pulses; done pulses once in the cycle after byte 64; err=0.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 repeatedly.
  - Required: out_data stable while stalled, no lost or duplicated bytes, next cs_n only after the 4th byte of each word.
- Variable latency:
  - Stimulus: ry delayed 1..10 cycles randomly; stray ry pulses in SEND and IDLE.
  - Required: byte stream identical to the normal run; stray ry has no effect.
- Timeout:
  - Stimulus: core stops answering at word 5 (no ry for 64 cycles).
  - Required: err=1, return to IDLE with word_cnt=5, no done. A following finish edge clears err and restarts at word 0.
- Reset mid-run:
  - Stimulus: rst asserted while in SEND of word 3, byte 2.
  - Required: next cycle cs_n=1, out_valid=0, busy=0, word_cnt=0. With finish still high and rst released, a fresh readout starts from word 0.
- Held finish:
  - Stimulus: finish held high through a completed run.
  - Required: no second readout until finish drops and rises again.

Source files
------------

// File: rtl/result_readout_if.sv
// Read port towards the matrix core's result memory plus the outgoing byte stream.
// The master side belongs to the readout engine; the slave side is the core plus the downstream sink.
interface result_readout_if;
  logic        cs_n;
  logic        ry;
  logic [31:0] read_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output cs_n,
    input  ry,
    input  read_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  cs_n,
    output ry,
    output read_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/result_readout.sv
// Fetches NUM_RESULTS result words from the core after each finish edge and streams
// them MSB byte first over valid/ready; sticky err if a read is never answered.
module result_readout #(
  parameter int NUM_RESULTS = 16,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                finish,
  result_readout_if.master    bus,
  output logic [CNT_W-1:0]    word_cnt,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic               finish_reg;
  logic [31:0]        shift_reg;
  logic [1:0]         byte_idx_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic               done_reg;
  logic               err_reg;

  logic start;
  logic beat;
  logic last_byte;
  logic last_word;
  logic timed_out;

  // Finish is a level from the core; only its rising edge launches a readout.
  assign start     = finish && !finish_reg;
  assign beat      = (state_reg == SEND) && bus.out_ready;
  assign last_byte = (byte_idx_reg == 2'd3);
  assign last_word = (word_cnt_reg == CNT_W'(NUM_RESULTS - 1));
  assign timed_out = (state_reg == WAIT) && !bus.ry && (timer_reg == TMR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: begin
        if (bus.ry) begin
          state_next = SEND;
        end else if (timed_out) begin
          state_next = IDLE;
        end
      end
      SEND: begin
        if (beat && last_byte) begin
          state_next = last_word ? IDLE : REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cs_n      = (state_reg != REQ);
    bus.out_valid = (state_reg == SEND);
    bus.out_data  = (state_reg == SEND) ? shift_reg[31:24] : 8'h00;
    busy          = (state_reg != IDLE);
    word_cnt      = word_cnt_reg;
    done          = done_reg;
    err           = err_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      finish_reg   <= 1'b0;
      shift_reg    <= '0;
      byte_idx_reg <= '0;
      timer_reg    <= '0;
      word_cnt_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      finish_reg <= finish;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err_reg      <= 1'b0;
            word_cnt_reg <= '0;
          end
        end
        REQ: timer_reg <= TMR_W'(TIMEOUT);
        WAIT: begin
          if (bus.ry) begin
            shift_reg    <= bus.read_data;
            byte_idx_reg <= 2'd0;
          end else begin
            timer_reg <= timer_reg - TMR_W'(1);
            if (timed_out) err_reg <= 1'b1;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            shift_reg    <= {shift_reg[23:0], 8'h00};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            // word_cnt parks on the final index so it still names the last word afterwards.
            if (last_byte) begin
              if (last_word) begin
                done_reg <= 1'b1;
              end else begin
                word_cnt_reg <= word_cnt_reg + CNT_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
